seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
- Receive-side counterpart of the clock's multiplexed 4-digit 7-segment display driver.
- Samples the anode-select and segment buses, waits for each digit to settle and decodes its pattern back to a BCD value.
- Publishes a complete 4-digit frame only after a clean full sweep.
- Used for on-board loopback self-check of the display path and as a bench monitor for the clock top level.

Parameters:
- SETTLE_CYC, 4, consecutive cycles (seg,vis) must be unchanged before a digit is accepted
- TIMEOUT_CYC, 1000000, cycles with no anode change before stale asserts
- CNT_W, 20, width of settle/timeout counter; must hold TIMEOUT_CYC

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- seg  in  4  anode select, active-low one-hot; seg[k]=0 selects digit k
- vis  in  7  segments, active-low, vis[6:0]=g,f,e,d,c,b,a
- dig0  out  4  minute units of last good frame
- dig1  out  4  minute tens
- dig2  out  4  hour units
- dig3  out  4  hour tens
- frame_valid  out  1  one-cycle pulse when dig0..dig3 update
- decode_err  out  1  sticky; set on any sweep error, cleared on next good frame
- stale  out  1  high while no anode change for TIMEOUT_CYC cycles

Behaviour:
- Reset (async, rst_n=0): dig0..3=0, frame_valid=0, decode_err=0, stale=0, FSM=SYNC, shadow regs and capture mask cleared, counters 0.
- seg and vis pass through a 2-flop synchroniser; all logic below sees the synchronised values (2-cycle input latency).
- Decode table, active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10. Any other pattern is invalid. All-off (7'h7F) is also invalid.
- Anode select: seg must be exactly one of 4'b1110/1101/1011/0111. Any other value is a bad anode.
- SYNC state:
  - Wait for seg to become 4'b1110 (digit 0).
  - Go to SETTLE with idx=0 and mask cleared.
- SETTLE state:
  - Counter increments while (seg,vis) equal the previous cycle; any change resets it to 0.
  - When it reaches SETTLE_CYC-1, decode vis.
  - Valid pattern: shadow[idx]=value, mask[idx]=1, go to HOLD.
  - Invalid pattern: decode_err=1, go to SYNC.
- HOLD state:
  - Wait for seg to change.
  - New seg selects idx+1 (mod 4): go to SETTLE with that idx.
  - Any other value (skip, repeat, bad anode): decode_err=1, go to SYNC.
- Frame commit:
  - Occurs in the cycle digit 3 is accepted with mask=4'b1111.
  - Next cycle: dig0..3 take shadow[0..3], frame_valid=1 for exactly one cycle, decode_err=0.
  - FSM then proceeds to HOLD for digit 3. The following 1110 starts a new sweep with mask cleared.
- Digit value written twice in a sweep (re-settle after glitch): not possible, since only a seg change leaves HOLD.
- Timeout counter:
  - Reset by any change of synchronised seg; saturates at TIMEOUT_CYC.
  - stale=1 while saturated, and drops the cycle after the next seg change.
  - stale does not alter dig outputs.
- Simultaneous commit and timeout saturation: commit still occurs.
- rst_n asserted mid-sweep: all state and outputs return to reset values immediately.
- Each BCD output is checked only for decode validity. No range check on hours or minutes (e.g. dig1=7 accepted).

Optional Feature:
- SEG_HEX_DECODE_EN
  - Defined: decode table extends to A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E, giving values 10..15.
  - Undefined: those patterns are invalid and set decode_err.

Decomposition:
- Shared package seg_pkg holds:
  - segment pattern constants SEG_0..SEG_9 (and SEG_A..SEG_F)
  - ANODE_D0..ANODE_D3 one-hot codes
  - FSM state encoding SYNC/SETTLE/HOLD
- One sub-module, seg7_to_bcd: combinational pattern to {valid,value[3:0]} lookup, honouring SEG_HEX_DECODE_EN.
- The same package constants serve the display-side encoder.

Test Plan:
- Sweep digits 0..3 with patterns 4,3,2,1 (7'h19,7'h30,7'h24,7'h79), 10 cycles each -> one frame_valid pulse; dig3..0=1,2,3,4; decode_err=0.
- Hold digit 1 at 7'h7F (blank) during a sweep -> decode_err=1, no frame_valid, dig outputs keep the prior frame; next clean sweep 0,0,0,0 -> frame_valid, decode_err=0.
- Toggle vis on every cycle for digit 2 for 20 cycles, then hold 7'h10 -> accepted only SETTLE_CYC cycles after it stops changing; frame gives dig2=9.
- Anode order 1110 then 1011 (skip digit 1) -> decode_err=1, FSM resyncs at next 1110.
- Freeze seg for TIMEOUT_CYC cycles (run with TIMEOUT_CYC=64) -> stale=1 at cycle 64+2 sync; one seg change -> stale=0.
- Pulse rst_n low mid-sweep after digits 0–1 are captured -> all outputs 0 asynchronously; the following full sweep commits normally. With SEG_HEX_DECODE_EN, pattern 7'h08 -> value 10; without it -> decode_err.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg
//   Shared constants for the 4-digit multiplexed 7-segment display path.
//   The display-side encoder drives these same codes, so the capture side
//   decodes exactly what the driver emits.
//   - SEG_0..SEG_F : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   - ANODE_D0..D3 : active-low one-hot anode selects
//   - state_t      : capture FSM state encoding
//   - anode_of()   : digit index -> anode select code
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [3:0] ANODE_D0 = 4'b1110;
    localparam logic [3:0] ANODE_D1 = 4'b1101;
    localparam logic [3:0] ANODE_D2 = 4'b1011;
    localparam logic [3:0] ANODE_D3 = 4'b0111;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    function automatic logic [3:0] anode_of(input logic [1:0] idx);
        logic [3:0] code;
        case (idx)
            2'd0:    code = ANODE_D0;
            2'd1:    code = ANODE_D1;
            2'd2:    code = ANODE_D2;
            default: code = ANODE_D3;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd
//   Combinational lookup of an active-low 7-segment pattern to its digit value.
//   Build option SEG_HEX_DECODE_EN: when defined, the A..F glyphs decode to
//   10..15; when undefined they are reported invalid like any other pattern.
//   Ports:
//     pat   in  7  segment pattern {g,f,e,d,c,b,a}, active-low
//     valid out 1  pattern is a recognised glyph
//     value out 4  decoded value (only meaningful when valid=1)
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] pat,
    output logic       valid,
    output logic [3:0] value
);

`ifdef SEG_HEX_DECODE_EN
    localparam bit HEX_EN = 1'b1;
`else
    localparam bit HEX_EN = 1'b0;
`endif

    always_comb begin
        valid = 1'b1;
        value = 4'h0;
        case (pat)
            SEG_0: value = 4'h0;
            SEG_1: value = 4'h1;
            SEG_2: value = 4'h2;
            SEG_3: value = 4'h3;
            SEG_4: value = 4'h4;
            SEG_5: value = 4'h5;
            SEG_6: value = 4'h6;
            SEG_7: value = 4'h7;
            SEG_8: value = 4'h8;
            SEG_9: value = 4'h9;
            SEG_A: begin valid = HEX_EN; value = 4'hA; end
            SEG_B: begin valid = HEX_EN; value = 4'hB; end
            SEG_C: begin valid = HEX_EN; value = 4'hC; end
            SEG_D: begin valid = HEX_EN; value = 4'hD; end
            SEG_E: begin valid = HEX_EN; value = 4'hE; end
            SEG_F: begin valid = HEX_EN; value = 4'hF; end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Watches the multiplexed anode/segment buses of the 4-digit display,
//   decodes each digit once it has been stable long enough and publishes a
//   4-digit frame only after a clean in-order sweep 0,1,2,3.
//   Build option SEG_HEX_DECODE_EN (see seg7_to_bcd) widens the glyph set.
//   Ports:
//     clk         in   system clock
//     rst_n       in   asynchronous active-low reset
//     seg         in   anode select, active-low one-hot
//     vis         in   segments, active-low {g,f,e,d,c,b,a}
//     dig0..dig3  out  digits of the last good frame (min units .. hour tens)
//     frame_valid out  one-cycle pulse when dig0..dig3 update
//     decode_err  out  sticky sweep error, cleared by the next good frame
//     stale       out  anode select has not changed for TIMEOUT_CYC cycles
//
//   state  | meaning
//   SYNC   | waiting for digit 0 anode to start a sweep
//   SETTLE | waiting for (seg,vis) to hold still, then decoding digit idx
//   HOLD   | digit idx captured, waiting for the anode to move on
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] seg,
    input  logic [6:0] vis,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       frame_valid,
    output logic       decode_err,
    output logic       stale
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_MAX      = CNT_W'(TIMEOUT_CYC);

    logic [3:0]       seg_m, seg_s, seg_p;
    logic [6:0]       vis_m, vis_s, vis_p;
    state_t           state, state_nx;
    logic [1:0]       idx, idx_nx, idx_inc;
    logic [3:0]       mask, mask_nx;
    logic [3:0][3:0]  shadow;
    logic [CNT_W-1:0] settle_cnt, settle_nx, to_cnt;
    logic             seg_chg, in_same;
    logic             shadow_we, err_set, commit;
    logic             dec_valid;
    logic [3:0]       dec_value;

    // Idle value (all off) keeps the first real anode edge visible as a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= 4'hF;
            seg_s <= 4'hF;
            seg_p <= 4'hF;
            vis_m <= SEG_OFF;
            vis_s <= SEG_OFF;
            vis_p <= SEG_OFF;
        end else begin
            seg_m <= seg;
            seg_s <= seg_m;
            seg_p <= seg_s;
            vis_m <= vis;
            vis_s <= vis_m;
            vis_p <= vis_s;
        end
    end

    assign seg_chg = (seg_s != seg_p);
    assign in_same = !seg_chg && (vis_s == vis_p);
    assign idx_inc = idx + 2'd1;

    seg7_to_bcd u_dec (
        .pat   (vis_s),
        .valid (dec_valid),
        .value (dec_value)
    );

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        mask_nx   = mask;
        settle_nx = settle_cnt;
        shadow_we = 1'b0;
        err_set   = 1'b0;
        commit    = 1'b0;
        case (state)
            SYNC: begin
                if (seg_s == ANODE_D0) begin
                    state_nx  = SETTLE;
                    idx_nx    = 2'd0;
                    mask_nx   = 4'b0000;
                    settle_nx = '0;
                end
            end
            SETTLE: begin
                // The anode moving mid-settle would file the pattern under
                // the wrong digit, so treat it as a broken sweep.
                if (seg_s != anode_of(idx)) begin
                    err_set  = 1'b1;
                    state_nx = SYNC;
                end else if (settle_cnt == SETTLE_LAST) begin
                    settle_nx = '0;
                    if (dec_valid) begin
                        shadow_we     = 1'b1;
                        mask_nx[idx]  = 1'b1;
                        state_nx      = HOLD;
                        commit        = (idx == 2'd3) && (mask[2:0] == 3'b111);
                    end else begin
                        err_set  = 1'b1;
                        state_nx = SYNC;
                    end
                end else if (in_same) begin
                    settle_nx = settle_cnt + 1'b1;
                end else begin
                    settle_nx = '0;
                end
            end
            HOLD: begin
                if (seg_chg) begin
                    if (seg_s == anode_of(idx_inc)) begin
                        state_nx  = SETTLE;
                        idx_nx    = idx_inc;
                        settle_nx = '0;
                        if (idx_inc == 2'd0) begin
                            mask_nx = 4'b0000;
                        end
                    end else begin
                        err_set  = 1'b1;
                        state_nx = SYNC;
                    end
                end
            end
            default: state_nx = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            idx        <= 2'd0;
            mask       <= 4'b0000;
            settle_cnt <= '0;
            shadow     <= '0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            mask       <= mask_nx;
            settle_cnt <= settle_nx;
            if (shadow_we) begin
                shadow[idx] <= dec_value;
            end
        end
    end

    // Digit 3 is still in flight on the commit edge, so it comes from the decoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig0        <= 4'h0;
            dig1        <= 4'h0;
            dig2        <= 4'h0;
            dig3        <= 4'h0;
            frame_valid <= 1'b0;
            decode_err  <= 1'b0;
        end else begin
            frame_valid <= commit;
            if (commit) begin
                dig0       <= shadow[0];
                dig1       <= shadow[1];
                dig2       <= shadow[2];
                dig3       <= dec_value;
                decode_err <= 1'b0;
            end else if (err_set) begin
                decode_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (seg_chg) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign stale = (to_cnt == TO_MAX);

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;
    import seg_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] seg;
    logic [6:0] vis;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic       frame_valid, decode_err, stale;
    logic [15:0] digs;

    int n_chk  = 0;
    int n_err  = 0;
    int fv_cnt = 0;
    int exp_fv = 0;

    seg_scan_capture #(
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (64),
        .CNT_W       (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .vis         (vis),
        .dig0        (dig0),
        .dig1        (dig1),
        .dig2        (dig2),
        .dig3        (dig3),
        .frame_valid (frame_valid),
        .decode_err  (decode_err),
        .stale       (stale)
    );

    assign digs = {dig3, dig2, dig1, dig0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && frame_valid) fv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic show(input int k, input logic [6:0] pat, input int n);
        seg = ~(4'b0001 << k);
        vis = pat;
        repeat (n) @(negedge clk);
    endtask

    task automatic sweep(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3);
        show(0, p0, 10);
        show(1, p1, 10);
        show(2, p2, 10);
        show(3, p3, 10);
    endtask

    initial begin
        rst_n = 1'b0;
        seg   = 4'hF;
        vis   = SEG_OFF;
        repeat (3) @(negedge clk);
        chk("rst_digs",  32'(digs), 32'h0000);
        chk("rst_fv",    32'(frame_valid), 32'd0);
        chk("rst_err",   32'(decode_err), 32'd0);
        chk("rst_stale", 32'(stale), 32'd0);
        rst_n = 1'b1;

        // Anodes frozen since reset: stale once the counter saturates at 64.
        repeat (60) @(negedge clk);
        chk("stale_pre", 32'(stale), 32'd0);
        repeat (6) @(negedge clk);
        chk("stale_sat", 32'(stale), 32'd1);

        // Clean sweep 4,3,2,1.
        sweep(SEG_4, SEG_3, SEG_2, SEG_1);
        exp_fv++;
        chk("sw1_fv",    32'(fv_cnt), 32'(exp_fv));
        chk("sw1_digs",  32'(digs), 32'h1234);
        chk("sw1_err",   32'(decode_err), 32'd0);
        chk("sw1_stale", 32'(stale), 32'd0);

        // Blank digit 1 breaks the sweep; prior frame is kept.
        show(0, SEG_0, 10);
        show(1, SEG_OFF, 10);
        chk("blank_err_now", 32'(decode_err), 32'd1);
        show(2, SEG_0, 10);
        show(3, SEG_0, 10);
        chk("blank_fv",   32'(fv_cnt), 32'(exp_fv));
        chk("blank_digs", 32'(digs), 32'h1234);

        sweep(SEG_0, SEG_0, SEG_0, SEG_0);
        exp_fv++;
        chk("zero_fv",   32'(fv_cnt), 32'(exp_fv));
        chk("zero_digs", 32'(digs), 32'h0000);
        chk("zero_err",  32'(decode_err), 32'd0);

        // Digit 2 flickers every cycle, then settles on 9.
        show(0, SEG_5, 10);
        show(1, SEG_6, 10);
        for (int i = 0; i < 20; i++) begin
            show(2, (i % 2 == 0) ? SEG_OFF : SEG_9, 1);
        end
        chk("glitch_err", 32'(decode_err), 32'd0);
        show(2, SEG_9, 10);
        show(3, SEG_7, 10);
        exp_fv++;
        chk("glitch_fv",   32'(fv_cnt), 32'(exp_fv));
        chk("glitch_digs", 32'(digs), 32'h7965);
        chk("glitch_err2", 32'(decode_err), 32'd0);

        // Skip from digit 0 straight to digit 2.
        show(0, SEG_8, 10);
        show(2, SEG_1, 10);
        chk("skip_err",  32'(decode_err), 32'd1);
        chk("skip_fv",   32'(fv_cnt), 32'(exp_fv));
        chk("skip_digs", 32'(digs), 32'h7965);

        sweep(SEG_9, SEG_8, SEG_0, SEG_2);
        exp_fv++;
        chk("resync_fv",   32'(fv_cnt), 32'(exp_fv));
        chk("resync_digs", 32'(digs), 32'h2089);
        chk("resync_err",  32'(decode_err), 32'd0);

        // Freeze on digit 3 long enough to go stale; dig outputs unaffected.
        show(3, SEG_2, 40);
        chk("frz_stale_pre", 32'(stale), 32'd0);
        show(3, SEG_2, 26);
        chk("frz_stale",     32'(stale), 32'd1);
        chk("frz_digs",      32'(digs), 32'h2089);
        show(0, SEG_3, 4);
        chk("frz_stale_clr", 32'(stale), 32'd0);
        show(0, SEG_3, 6);
        show(1, SEG_4, 10);

        // Asynchronous reset mid-sweep.
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_digs",  32'(digs), 32'h0000);
        chk("mrst_fv",    32'(frame_valid), 32'd0);
        chk("mrst_err",   32'(decode_err), 32'd0);
        chk("mrst_stale", 32'(stale), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(SEG_3, SEG_4, SEG_5, SEG_6);
        exp_fv++;
        chk("post_fv",   32'(fv_cnt), 32'(exp_fv));
        chk("post_digs", 32'(digs), 32'h6543);
        chk("post_err",  32'(decode_err), 32'd0);

        // Hex glyph 'A' on digit 0.
        sweep(SEG_A, SEG_1, SEG_2, SEG_3);
`ifdef SEG_HEX_DECODE_EN
        exp_fv++;
        chk("hex_digs", 32'(digs), 32'h321A);
        chk("hex_err",  32'(decode_err), 32'd0);
`else
        chk("hex_digs", 32'(digs), 32'h6543);
        chk("hex_err",  32'(decode_err), 32'd1);
`endif
        chk("hex_fv", 32'(fv_cnt), 32'(exp_fv));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
